// File: rtl/drop_pkg.sv
// Shared state encoding and default timing constants for the drop timer and playfield controller.
// Optional hard-drop support is enabled by DROP_TIMER_HARD_DROP_EN in the consumers.
package drop_pkg;

    localparam int unsigned CNT_W_DEF       = 28;
    localparam int unsigned BASE_PERIOD_DEF = 33554432;
    localparam int unsigned FAST_PERIOD_DEF = 4194304;
    localparam int unsigned LEVEL_STEP_DEF  = 2097152;
    localparam int unsigned MIN_PERIOD_DEF  = 1048576;
    localparam int unsigned LOCK_CYCLES_DEF = 16777216;
    localparam int unsigned MAX_RESETS_DEF  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_LOCK = 2'd2,
        ST_HARD = 2'd3
    } drop_state_e;

endpackage

// File: rtl/drop_timer_period_calc.sv
// Combinational fall-period calculation from level and soft-drop, clamped to the floor.
module drop_timer_period_calc
    import drop_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned BASE_PERIOD = BASE_PERIOD_DEF,
    parameter int unsigned FAST_PERIOD = FAST_PERIOD_DEF,
    parameter int unsigned LEVEL_STEP  = LEVEL_STEP_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF
) (
    input  logic [3:0]       level,
    input  logic             soft_drop,
    output logic [CNT_W-1:0] eff_period_c
);

    logic [CNT_W:0]   step_prod;
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] period;

    // One extra bit catches the borrow so a large level clamps instead of wrapping.
    always_comb begin
        step_prod = (CNT_W+1)'(level) * (CNT_W+1)'(LEVEL_STEP);
        diff      = (CNT_W+1)'(BASE_PERIOD) - step_prod;
        if (diff[CNT_W] || (diff < (CNT_W+1)'(MIN_PERIOD))) begin
            period = CNT_W'(MIN_PERIOD);
        end else begin
            period = diff[CNT_W-1:0];
        end
        if (soft_drop && (period > CNT_W'(FAST_PERIOD))) begin
            eff_period_c = CNT_W'(FAST_PERIOD);
        end else begin
            eff_period_c = period;
        end
    end

endmodule

// File: rtl/drop_timer.sv
// Gravity and lock-delay timing engine; emits single-cycle drop_tick and lock_req enables.
// Define DROP_TIMER_HARD_DROP_EN to add the hard_drop input and HARD state.
module drop_timer
    import drop_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned BASE_PERIOD = BASE_PERIOD_DEF,
    parameter int unsigned FAST_PERIOD = FAST_PERIOD_DEF,
    parameter int unsigned LEVEL_STEP  = LEVEL_STEP_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int unsigned MAX_RESETS  = MAX_RESETS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       pause,
    input  logic       landed,
    input  logic       move_done,
`ifdef DROP_TIMER_HARD_DROP_EN
    input  logic       hard_drop,
`endif
    output logic       drop_tick,
    output logic       lock_req,
    output logic       busy,
    output logic [1:0] state_o
);

    localparam int unsigned RES_W = $clog2(MAX_RESETS + 1);

    drop_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [RES_W-1:0] resets_used_q, resets_used_d;
    logic             drop_tick_q, drop_tick_d;
    logic             lock_req_q, lock_req_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] eff_period_c;

    drop_timer_period_calc #(
        .CNT_W       (CNT_W),
        .BASE_PERIOD (BASE_PERIOD),
        .FAST_PERIOD (FAST_PERIOD),
        .LEVEL_STEP  (LEVEL_STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_period_calc (
        .level        (level),
        .soft_drop    (soft_drop),
        .eff_period_c (eff_period_c)
    );

    // Next-state and next-output logic; pause holds everything and silences pulses.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lock_cnt_d    = lock_cnt_q;
        resets_used_d = resets_used_q;
        drop_tick_d   = 1'b0;
        lock_req_d    = 1'b0;
        if (!pause) begin
            if (spawn) begin
                state_d       = ST_FALL;
                cnt_d         = '0;
                lock_cnt_d    = '0;
                resets_used_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                    end
                    ST_FALL: begin
`ifdef DROP_TIMER_HARD_DROP_EN
                        if (hard_drop) begin
                            state_d = ST_HARD;
                            cnt_d   = '0;
                        end else
`endif
                        if (landed) begin
                            state_d    = ST_LOCK;
                            lock_cnt_d = '0;
                            cnt_d      = '0;
                        end else if (cnt_q >= (eff_period_c - CNT_W'(1))) begin
                            drop_tick_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_LOCK: begin
                        if (!landed) begin
                            state_d = ST_FALL;
                            cnt_d   = '0;
                        end else if (move_done && (resets_used_q < RES_W'(MAX_RESETS))) begin
                            lock_cnt_d    = '0;
                            resets_used_d = resets_used_q + RES_W'(1);
                        end else if (lock_cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                            lock_req_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            lock_cnt_d = lock_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
`ifdef DROP_TIMER_HARD_DROP_EN
                        if (landed) begin
                            lock_req_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            drop_tick_d = 1'b1;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                endcase
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            lock_cnt_q    <= '0;
            resets_used_q <= '0;
            drop_tick_q   <= 1'b0;
            lock_req_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            resets_used_q <= resets_used_d;
            drop_tick_q   <= drop_tick_d;
            lock_req_q    <= lock_req_d;
            busy_q        <= busy_d;
        end
    end

    assign drop_tick = drop_tick_q;
    assign lock_req  = lock_req_q;
    assign busy      = busy_q;
    assign state_o   = 2'(state_q);

endmodule

// File: doc/drop_timer.md
Name: drop_timer

Overview:
- Gravity/lock timing engine for the falling-block game. Sits between the free-running clock divider and the block-movement logic.
- Produces single-cycle enables in the main clk domain instead of consuming divided clocks as clocks.
- Computes the fall period from level and soft-drop. Runs a lock-delay state machine once the piece lands.
- Emits drop_tick (move piece down one row) and lock_req (freeze piece, spawn next).

Parameters:
- CNT_W, 28, width of period counter
- BASE_PERIOD, 33554432, fall period in clk cycles at level 0 (2^25)
- FAST_PERIOD, 4194304, soft-drop fall period (2^22)
- LEVEL_STEP, 2097152, cycles removed from period per level
- MIN_PERIOD, 1048576, floor on level-derived period
- LOCK_CYCLES, 16777216, lock-delay length in cycles
- MAX_RESETS, 15, maximum lock-delay restarts per piece

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- spawn  in  1  pulse: new piece placed; starts timing
- level  in  4  current game level, 0..15
- soft_drop  in  1  level: player holding down
- pause  in  1  level: freeze all counters and state
- landed  in  1  level: piece cannot move down
- move_done  in  1  pulse: successful player move/rotate
- drop_tick  out  1  pulse: move piece down one row
- lock_req  out  1  pulse: lock piece
- busy  out  1  high in FALL or LOCK
- state_o  out  2  current state encoding

Behaviour:
- Reset: state IDLE, cnt=0, lock_cnt=0, resets_used=0. drop_tick=0, lock_req=0, busy=0, state_o=0.
- States: IDLE=0, FALL=1, LOCK=2. All outputs registered, so pulses appear the cycle after their cause.
- period = max(BASE_PERIOD - level*LEVEL_STEP, MIN_PERIOD). Subtract with CNT_W+1 bits and clamp; no underflow wrap allowed.
- If soft_drop is high, eff_period = min(period, FAST_PERIOD). Otherwise eff_period = period.
- IDLE: spawn -> FALL, cnt=0, resets_used=0. Other inputs ignored.
- FALL, !landed: cnt increments. When cnt >= eff_period-1: drop_tick pulses next cycle and cnt=0. The >= compare handles soft_drop or level changes mid-count, so a shortened period ticks immediately.
- FALL, landed: -> LOCK, lock_cnt=0, cnt=0. No drop_tick is issued that cycle.
- LOCK, landed high: lock_cnt increments.
  - When lock_cnt == LOCK_CYCLES-1: lock_req pulses, go to IDLE.
  - move_done with resets_used < MAX_RESETS: lock_cnt=0 and resets_used++.
  - move_done with resets_used == MAX_RESETS: ignored.
- LOCK, landed drops to 0: -> FALL with cnt=0. resets_used is kept.
- pause high: counters and state hold; drop_tick/lock_req forced 0; spawn ignored.
- spawn in FALL or LOCK: restart as from IDLE. No lock_req is issued.
- Simultaneous events in LOCK: move_done and lock expiry in the same cycle -> move_done wins and no lock. In FALL, landed and a tick-due cycle together -> landed wins.
- rst mid-operation clears everything immediately (asynchronous). No pulse is emitted on release.

Optional Feature:
- Macro: DROP_TIMER_HARD_DROP_EN.
- When defined:
  - Adds input hard_drop (1, pulse) and an internal HARD state (encoding 3).
  - hard_drop in FALL -> HARD.
  - HARD emits drop_tick every cycle while !landed.
  - When landed is seen in HARD: lock_req next cycle, then IDLE, with no lock delay.
  - pause still freezes HARD.
- When undefined: no port, no state 3; behaviour exactly as above.

Decomposition:
- Shared package drop_pkg holds the state encoding constants (IDLE/FALL/LOCK/HARD) and the default period constants, reused by the playfield controller.
- One natural sub-module: period_calc. It is combinational: level, soft_drop -> eff_period, with clamping. Instantiate it once.

Test Plan (use BASE_PERIOD=40, FAST_PERIOD=8, LEVEL_STEP=4, MIN_PERIOD=6, LOCK_CYCLES=10, MAX_RESETS=2):
- spawn, level=0, landed=0 -> drop_tick 40 cycles apart, first one 40 cycles after spawn.
- level=15 -> period clamps to 6, ticks every 6 cycles. With soft_drop at level 0 -> every 8. soft_drop asserted at cnt=20 -> tick on the next cycle.
- landed asserted in FALL -> no further ticks, lock_req exactly 10 cycles later, then state_o=0.
- In LOCK, three move_done pulses spaced 5 cycles apart -> first two restart the delay, third ignored. lock_req comes 10 cycles after the second restart.
- pause for 17 cycles mid-FALL -> tick delayed by exactly 17 cycles. rst asserted in LOCK -> outputs 0 immediately and no lock_req.
- With DROP_TIMER_HARD_DROP_EN: hard_drop with landed after 3 cycles -> 3 consecutive drop_ticks, then lock_req one cycle after landed.
